// File: rtl/bridge_pkg.sv
// Shared definitions for the system bridge: memory access encodings,
// exception codes, timer register offsets and timer FSM state encoding.
package bridge_pkg;

   localparam int MEM_MODE_LEN = 2;
   localparam logic [MEM_MODE_LEN-1:0] MEM_MODE_NONE  = 2'd0;
   localparam logic [MEM_MODE_LEN-1:0] MEM_MODE_READ  = 2'd1;
   localparam logic [MEM_MODE_LEN-1:0] MEM_MODE_WRITE = 2'd2;

   localparam int MEM_TYPE_LEN = 2;
   localparam logic [MEM_TYPE_LEN-1:0] MEM_TYPE_BYTE = 2'd0;
   localparam logic [MEM_TYPE_LEN-1:0] MEM_TYPE_HALF = 2'd1;
   localparam logic [MEM_TYPE_LEN-1:0] MEM_TYPE_WORD = 2'd2;

   localparam int EXC_CODE_LEN = 5;
   localparam logic [EXC_CODE_LEN-1:0] EXC_CODE_NONE = 5'd0;
   localparam logic [EXC_CODE_LEN-1:0] EXC_CODE_ADEL = 5'd4;
   localparam logic [EXC_CODE_LEN-1:0] EXC_CODE_ADES = 5'd5;

   // Byte offsets of the timer registers inside a 16-byte block
   localparam logic [3:0] TIMER_CTRL_OFF   = 4'h0;
   localparam logic [3:0] TIMER_PRESET_OFF = 4'h4;
   localparam logic [3:0] TIMER_COUNT_OFF  = 4'h8;

   // Word selects derived from the byte offsets (addr[3:2])
   localparam logic [1:0] TIMER_SEL_CTRL   = TIMER_CTRL_OFF[3:2];
   localparam logic [1:0] TIMER_SEL_PRESET = TIMER_PRESET_OFF[3:2];
   localparam logic [1:0] TIMER_SEL_COUNT  = TIMER_COUNT_OFF[3:2];

   typedef enum logic [1:0] {
      TIMER_ST_IDLE = 2'd0,
      TIMER_ST_LOAD = 2'd1,
      TIMER_ST_CNT  = 2'd2,
      TIMER_ST_INT  = 2'd3
   } timer_state_e;

   // CTRL keeps only four bits; the rest of the word reads as zero
   function automatic logic [31:0] timer_ctrl_word(input logic [3:0] ctrl);
      return {28'd0, ctrl};
   endfunction

endpackage

// File: rtl/bridge_timer.sv
// One memory-mapped timer: CTRL/PRESET/COUNT registers, countdown FSM and
// interrupt flag. Register writes take priority over the FSM on the same edge.
module timer
   import bridge_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [1:0]  reg_sel,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        irq
);

   logic [3:0]   ctrl_q, ctrl_d;
   logic [31:0]  preset_q, preset_d;
   logic [31:0]  count_q, count_d;
   logic         flag_q, flag_d;
   timer_state_e state_q, state_d;

   logic wr_cfg;
   logic auto_reload;

   assign wr_cfg      = we && ((reg_sel == TIMER_SEL_CTRL) || (reg_sel == TIMER_SEL_PRESET));
   assign auto_reload = (ctrl_q[2:1] == 2'b01);
   assign irq         = flag_q & ctrl_q[3];

   // Next-state: a CTRL/PRESET write restarts the timer, otherwise run the FSM
   always_comb begin
      ctrl_d   = ctrl_q;
      preset_d = preset_q;
      count_d  = count_q;
      flag_d   = flag_q;
      state_d  = state_q;
      if (wr_cfg) begin
         if (reg_sel == TIMER_SEL_CTRL) begin
            ctrl_d = write_data[3:0];
         end else begin
            preset_d = write_data;
         end
         state_d = TIMER_ST_IDLE;
         flag_d  = 1'b0;
      end else begin
         unique case (state_q)
            TIMER_ST_IDLE: begin
               if (ctrl_q[0]) state_d = TIMER_ST_LOAD;
            end
            TIMER_ST_LOAD: begin
               count_d = preset_q;
               state_d = TIMER_ST_CNT;
            end
            TIMER_ST_CNT: begin
               if (!ctrl_q[0]) begin
                  state_d = TIMER_ST_IDLE;
               end else if (count_q > 32'd1) begin
                  count_d = count_q - 32'd1;
               end else begin
                  // Expiry; a PRESET of 0 lands here too and behaves like 1
                  count_d = 32'd0;
                  flag_d  = 1'b1;
                  if (auto_reload) begin
                     state_d = TIMER_ST_INT;
                  end else begin
                     ctrl_d[0] = 1'b0;
                     state_d   = TIMER_ST_IDLE;
                  end
               end
            end
            TIMER_ST_INT: begin
               flag_d  = 1'b0;
               state_d = TIMER_ST_LOAD;
            end
            default: state_d = TIMER_ST_IDLE;
         endcase
      end
   end

   // Register all timer state; async active-low reset clears everything
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl_q   <= 4'd0;
         preset_q <= 32'd0;
         count_q  <= 32'd0;
         flag_q   <= 1'b0;
         state_q  <= TIMER_ST_IDLE;
      end else begin
         ctrl_q   <= ctrl_d;
         preset_q <= preset_d;
         count_q  <= count_d;
         flag_q   <= flag_d;
         state_q  <= state_d;
      end
   end

   // Register read mux; select 3 is unmapped and reads zero
   always_comb begin
      read_data = 32'd0;
      unique case (reg_sel)
         TIMER_SEL_CTRL:   read_data = timer_ctrl_word(ctrl_q);
         TIMER_SEL_PRESET: read_data = preset_q;
         TIMER_SEL_COUNT:  read_data = count_q;
         default:          read_data = 32'd0;
      endcase
   end

endmodule

// File: rtl/bridge.sv
// System bridge behind the memory stage: address decode, combinational
// exception and read path, and two timers whose irqs go to CP0.
// The access-size port is called mem_type because "type" is a reserved word.
module bridge
   import bridge_pkg::*;
#(
   parameter logic [31:0] TIMER0_BASE = 32'h0000_7f00,
   parameter logic [31:0] TIMER1_BASE = 32'h0000_7f10
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [31:0]             addr,
   input  logic [31:0]             write_data,
   input  logic [MEM_TYPE_LEN-1:0] mem_type,
   input  logic [MEM_MODE_LEN-1:0] mode,
   input  logic                    int_req,
   output logic [31:0]             read_data,
   output logic [EXC_CODE_LEN-1:0] exc,
   output logic [1:0]              irq
);

   logic [1:0]  reg_sel;
   logic        hit0, hit1, mapped;
   logic        commit;
   logic [31:0] rd0, rd1;
   logic [1:0]  unused_addr;

   // Byte-lane bits do not take part in decode
   assign unused_addr = addr[1:0];

   assign reg_sel = addr[3:2];
   assign hit0    = (addr[31:4] == TIMER0_BASE[31:4]);
   assign hit1    = (addr[31:4] == TIMER1_BASE[31:4]);
   assign mapped  = (hit0 || hit1) && (reg_sel != 2'b11);

   // Classify the access: bad address or non-word size faults, COUNT is read-only
   always_comb begin
      exc = EXC_CODE_NONE;
      unique case (mode)
         MEM_MODE_READ: begin
            if (!mapped || (mem_type != MEM_TYPE_WORD)) exc = EXC_CODE_ADEL;
         end
         MEM_MODE_WRITE: begin
            if (!mapped || (mem_type != MEM_TYPE_WORD) || (reg_sel == TIMER_SEL_COUNT))
               exc = EXC_CODE_ADES;
         end
         default: exc = EXC_CODE_NONE;
      endcase
   end

   // Return the selected register only for a clean read
   always_comb begin
      read_data = 32'd0;
      if ((mode == MEM_MODE_READ) && (exc == EXC_CODE_NONE)) begin
         read_data = hit0 ? rd0 : rd1;
      end
   end

   // A pending interrupt/exception cancels the store
   assign commit = (mode == MEM_MODE_WRITE) && (exc == EXC_CODE_NONE) && !int_req;

   timer u_timer0 (
      .clk        (clk),
      .reset      (reset),
      .we         (commit && hit0),
      .reg_sel    (reg_sel),
      .write_data (write_data),
      .read_data  (rd0),
      .irq        (irq[0])
   );

   timer u_timer1 (
      .clk        (clk),
      .reset      (reset),
      .we         (commit && hit1),
      .reg_sel    (reg_sel),
      .write_data (write_data),
      .read_data  (rd1),
      .irq        (irq[1])
   );

endmodule

// File: tb/tb_bridge.sv
// Scoreboard bench for the bridge. The timer reference model is timestamp
// based: each timer remembers the edge it was (re)configured on and derives
// COUNT/flag for any later edge arithmetically.
module tb_bridge;
   import bridge_pkg::*;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [31:0]             addr;
   logic [31:0]             write_data;
   logic [MEM_TYPE_LEN-1:0] mem_type;
   logic [MEM_MODE_LEN-1:0] mode;
   logic                    int_req;
   logic [31:0]             read_data;
   logic [EXC_CODE_LEN-1:0] exc;
   logic [1:0]              irq;

   bridge #(.TIMER0_BASE(32'h7f00), .TIMER1_BASE(32'h7f10)) dut (
      .clk        (clk),
      .reset      (reset),
      .addr       (addr),
      .write_data (write_data),
      .mem_type   (mem_type),
      .mode       (mode),
      .int_req    (int_req),
      .read_data  (read_data),
      .exc        (exc),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   int ecnt = 0;
   always @(posedge clk) ecnt <= ecnt + 1;

   typedef struct packed {
      logic [31:0]             rd;
      logic [EXC_CODE_LEN-1:0] ex;
      logic [1:0]              iq;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model state per timer
   logic [3:0]  m_ctrl   [2];
   logic [31:0] m_preset [2];
   logic [31:0] m_hold   [2];
   int          m_start  [2];

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_ctrl[i]   = 4'd0;
         m_preset[i] = 32'd0;
         m_hold[i]   = 32'd0;
         m_start[i]  = 0;
      end
   endfunction

   // State of timer i as seen after edge t
   function automatic void mdl(input int i, input int t, output logic [31:0] cnt,
                               output logic flg, output logic en);
      longint k, p, pp, j;
      p   = longint'(m_preset[i]);
      pp  = (p == 0) ? 1 : p;
      k   = longint'(t - m_start[i]);
      cnt = m_hold[i];
      flg = 1'b0;
      en  = m_ctrl[i][0];
      if (m_ctrl[i][0] && k >= 2) begin
         if (m_ctrl[i][2:1] == 2'b01) begin
            j   = (k - 2) % (pp + 2);
            cnt = (j < pp) ? 32'(p - j) : 32'd0;
            flg = (j == pp);
         end else if (k - 2 < pp) begin
            cnt = 32'(p - (k - 2));
         end else begin
            cnt = 32'd0;
            flg = 1'b1;
            en  = 1'b0;
         end
      end
   endfunction

   function automatic logic [31:0] model_reg(input int i, input logic [1:0] sel, input int t);
      logic [31:0] c;
      logic f, e;
      mdl(i, t, c, f, e);
      case (sel)
         2'd0:    return {28'd0, m_ctrl[i][3:1], e};
         2'd1:    return m_preset[i];
         2'd2:    return c;
         default: return 32'd0;
      endcase
   endfunction

   // Drive one access now, push its expected response, update the model
   task automatic issue_now(input logic [31:0] a, input logic [31:0] wd,
                            input logic [1:0] ty, input logic [1:0] md, input logic ir);
      int          t, ti;
      logic        h0, h1, mp;
      logic [1:0]  sel;
      logic [4:0]  e;
      logic [31:0] c;
      logic        f, en;
      exp_t        x;
      addr = a; write_data = wd; mem_type = ty; mode = md; int_req = ir;
      t   = ecnt;
      h0  = (a[31:4] == 28'h00007f0);
      h1  = (a[31:4] == 28'h00007f1);
      ti  = h1 ? 1 : 0;
      sel = a[3:2];
      mp  = (h0 || h1) && (sel != 2'd3);
      e   = EXC_CODE_NONE;
      if (md == MEM_MODE_READ && (!mp || ty != MEM_TYPE_WORD)) e = EXC_CODE_ADEL;
      if (md == MEM_MODE_WRITE && (!mp || ty != MEM_TYPE_WORD || sel == 2'd2)) e = EXC_CODE_ADES;
      x.rd = (md == MEM_MODE_READ && e == EXC_CODE_NONE) ? model_reg(ti, sel, t) : 32'd0;
      x.ex = e;
      for (int i = 0; i < 2; i++) begin
         mdl(i, t, c, f, en);
         x.iq[i] = f & m_ctrl[i][3];
      end
      exp_q.push_back(x);
      if (md == MEM_MODE_WRITE && e == EXC_CODE_NONE && !ir && reset) begin
         mdl(ti, t, c, f, en);
         m_hold[ti]    = c;
         m_ctrl[ti][0] = en;
         if (sel == 2'd0) m_ctrl[ti] = wd[3:0];
         else             m_preset[ti] = wd;
         m_start[ti] = t + 1;
      end
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] ty, input logic [1:0] md, input logic ir);
      @(posedge clk); #1;
      issue_now(a, wd, ty, md, ir);
   endtask

   task automatic rd(input logic [31:0] a);
      issue(a, 32'd0, MEM_TYPE_WORD, MEM_MODE_READ, 1'b0);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      issue(a, d, MEM_TYPE_WORD, MEM_MODE_WRITE, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) issue(32'd0, 32'd0, MEM_TYPE_WORD, MEM_MODE_NONE, 1'b0);
   endtask

   task automatic rd_n(input logic [31:0] a, input int n);
      for (int i = 0; i < n; i++) rd(a);
   endtask

   // Monitor: compare the presented response mid-cycle against the queue head
   always @(negedge clk) begin
      exp_t x;
      if (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         total = total + 3;
         if (read_data !== x.rd) begin
            bad = bad + 1;
            $display("FAIL read_data @%0t: got=%h want=%h", $time, read_data, x.rd);
         end
         if (exc !== x.ex) begin
            bad = bad + 1;
            $display("FAIL exc @%0t: got=%0d want=%0d", $time, exc, x.ex);
         end
         if (irq !== x.iq) begin
            bad = bad + 1;
            $display("FAIL irq @%0t: got=%b want=%b", $time, irq, x.iq);
         end
      end
   end

   initial begin
      logic [31:0] a, wd;
      logic [1:0]  ty, md, sel;
      logic        ir;
      int          r, ti;

      reset = 1'b0; addr = 32'd0; write_data = 32'd0;
      mem_type = MEM_TYPE_WORD; mode = MEM_MODE_NONE; int_req = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // Reset state of every register
      rd(32'h7f00); rd(32'h7f04); rd(32'h7f08);
      rd(32'h7f10); rd(32'h7f14); rd(32'h7f18);

      // Asynchronous reset in the middle of a count
      wr(32'h7f04, 32'd100); wr(32'h7f00, 32'd1);
      rd_n(32'h7f08, 10);
      @(posedge clk); #2;
      reset = 1'b0;
      model_reset();
      issue_now(32'h7f08, 32'd0, MEM_TYPE_WORD, MEM_MODE_READ, 1'b0);
      rd(32'h7f00); rd(32'h7f04);
      @(posedge clk); #1 reset = 1'b1;
      rd_n(32'h7f08, 4);

      // One-shot: PRESET=5, CTRL=IM|EN, then clear with CTRL=0
      wr(32'h7f04, 32'd5); wr(32'h7f00, 32'h9);
      rd_n(32'h7f08, 9);
      rd(32'h7f00);
      idle(3);
      wr(32'h7f00, 32'h0);
      rd_n(32'h7f08, 2);

      // Auto-reload on Timer1: PRESET=3, CTRL=IM|auto|EN
      wr(32'h7f14, 32'd3); wr(32'h7f10, 32'hb);
      rd_n(32'h7f18, 20);
      wr(32'h7f10, 32'h0);

      // Masked expiry, then enabling IM clears the stale flag
      wr(32'h7f04, 32'd2); wr(32'h7f00, 32'h1);
      rd_n(32'h7f08, 6);
      wr(32'h7f00, 32'h9);
      rd_n(32'h7f08, 6);

      // PRESET of zero behaves as one
      wr(32'h7f04, 32'd0); wr(32'h7f00, 32'h9);
      rd_n(32'h7f08, 5);

      // Exception cases
      wr(32'h7f04, 32'd42);
      rd(32'h7f0c);
      wr(32'h7f08, 32'd77);
      rd(32'h7f08);
      issue(32'h7f00, 32'h9, MEM_TYPE_BYTE, MEM_MODE_WRITE, 1'b0);
      issue(32'h7f04, 32'd0, MEM_TYPE_HALF, MEM_MODE_READ, 1'b0);
      rd(32'h8000);
      rd(32'h7f04);

      // int_req suppresses the store
      issue(32'h7f04, 32'd99, MEM_TYPE_WORD, MEM_MODE_WRITE, 1'b1);
      rd(32'h7f04);

      // CTRL write while counting restarts the timer
      wr(32'h7f04, 32'd10); wr(32'h7f00, 32'h9);
      rd_n(32'h7f08, 5);
      wr(32'h7f00, 32'h9);
      rd_n(32'h7f08, 15);
      wr(32'h7f00, 32'h8);
      rd_n(32'h7f08, 3);

      // Randomized traffic on both timers
      for (int n = 0; n < 1500; n++) begin
         r   = int'($urandom_range(0, 99));
         ti  = int'($urandom_range(0, 1));
         sel = 2'($urandom_range(0, 3));
         a   = (ti == 1 ? 32'h7f10 : 32'h7f00) + {28'd0, sel, 2'b00};
         if (r < 4) a = $urandom;
         ty  = (r % 10 == 7) ? 2'($urandom_range(0, 1)) : MEM_TYPE_WORD;
         md  = (r < 40) ? MEM_MODE_READ : (r < 65) ? MEM_MODE_WRITE : MEM_MODE_NONE;
         wd  = (sel == 2'd0) ? $urandom : 32'($urandom_range(0, 8));
         ir  = ($urandom_range(0, 7) == 0);
         issue(a, wd, ty, md, ir);
      end

      // Drain the scoreboard
      @(posedge clk); #1;
      mode = MEM_MODE_NONE;
      @(negedge clk); #1;
      total = total + 1;
      if (exp_q.size() != 0) begin
         bad = bad + 1;
         $display("FAIL drain: got=%0d pending want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
